stack_ctrl: RTL

- Sequential operand-stack controller for the single-cycle stack CPU.
- Consumes the decoder's stack strobes (read_reg1, read_reg2, write_reg) once per executed instruction.
- Owns the stack storage and stack pointer, presents the top two entries to the ALU and memory datapath, and pushes the writeback value.
- Detects overflow and underflow, and holds a sticky fault state that blocks further stack updates until cleared.

---
 rtl/stack_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: operand-stack controller for the single-cycle stack CPU (storage, sp, fault FSM).
// Latency: one update per valid edge; top0/top1 are combinational reads of the registered sp.
// Backpressure: none; a sticky FAULT state blocks updates until clear_fault. Optional: STACK_HIGHWATER_EN.
module stack_ctrl #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int SPW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic             read_reg1,
   input  logic             read_reg2,
   input  logic             write_reg,
   input  logic [WIDTH-1:0] push_data,
   input  logic             clear_fault,
   output logic [WIDTH-1:0] top0,
   output logic [WIDTH-1:0] top1,
   output logic [SPW-1:0]   sp,
   output logic             empty,
   output logic             full,
   output logic             fault,
   output logic [1:0]       fault_code
`ifdef STACK_HIGHWATER_EN
   ,
   output logic [SPW-1:0]   hiwater
`endif
);

   // Index width into the storage array; DEPTH is a power of two so SPW == IW + 1.
   localparam int IW = $clog2(DEPTH);

   // Occupancy arithmetic is done one bit wider than sp so that DEPTH+1 and
   // underflow wrap-around are distinguishable from legal values.
   localparam logic [SPW:0] DEPTH_X = (SPW + 1)'(DEPTH);

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_UNDER = 2'b01;
   localparam logic [1:0] FC_OVER  = 2'b10;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t           state_q;
   logic             fault_q;
   logic [1:0]       fault_code_q;
   logic [SPW-1:0]   sp_q;
   logic [SPW-1:0]   sp_d;
   logic [WIDTH-1:0] stack_q [DEPTH];

   logic [SPW:0]     sp_x;
   logic [SPW:0]     pops_x;
   logic [SPW:0]     push_x;
   logic [SPW:0]     rem_x;
   logic [SPW:0]     nxt_x;
   logic             req;
   logic             underflow;
   logic             overflow;
   logic             legal;
   logic             do_write;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd0_idx;
   logic [IW-1:0]    rd1_idx;

   // Decode the stack strobes and classify the request as underflow, overflow or legal.
   always_comb begin
      pops_x = '0;
      if (read_reg2) begin
         pops_x = (SPW + 1)'(2);
      end else if (read_reg1) begin
         pops_x = (SPW + 1)'(1);
      end
      push_x    = {{SPW{1'b0}}, write_reg};
      sp_x      = {1'b0, sp_q};
      req       = (state_q == ST_RUN) && valid;
      // Underflow takes priority; rem_x may wrap in that case but is then unused.
      underflow = req && (pops_x > sp_x);
      rem_x     = sp_x - pops_x;
      nxt_x     = rem_x + push_x;
      overflow  = req && !underflow && (nxt_x > DEPTH_X);
      legal     = req && !underflow && !overflow;
      // A push lands in the slot just freed by any pops (or the next free slot).
      do_write  = legal && write_reg;
      wr_idx    = IW'(rem_x);
      sp_d      = legal ? SPW'(nxt_x) : sp_q;
   end

   // Read the top two entries from the registered sp; absent entries read as zero.
   always_comb begin
      rd0_idx = IW'(sp_q - SPW'(1));
      rd1_idx = IW'(sp_q - SPW'(2));
      top0    = '0;
      top1    = '0;
      if (sp_q != '0) begin
         top0 = stack_q[rd0_idx];
      end
      if (sp_q > SPW'(1)) begin
         top1 = stack_q[rd1_idx];
      end
   end

   // Stack storage: cleared on reset, written only by a legal push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else if (do_write) begin
         stack_q[wr_idx] <= push_data;
      end
   end

   // Stack pointer: moves only on a legal update, frozen otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Fault FSM with registered fault flag and sticky fault code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         fault_q      <= 1'b0;
         fault_code_q <= FC_NONE;
      end else begin
         case (state_q)
            ST_RUN: begin
               // clear_fault is meaningless here, so a fault in the same cycle always wins.
               if (underflow) begin
                  state_q      <= ST_FAULT;
                  fault_q      <= 1'b1;
                  fault_code_q <= FC_UNDER;
               end else if (overflow) begin
                  state_q      <= ST_FAULT;
                  fault_q      <= 1'b1;
                  fault_code_q <= FC_OVER;
               end
            end
            ST_FAULT: begin
               if (clear_fault) begin
                  state_q      <= ST_RUN;
                  fault_q      <= 1'b0;
                  fault_code_q <= FC_NONE;
               end
            end
            default: begin
               state_q      <= ST_RUN;
               fault_q      <= 1'b0;
               fault_code_q <= FC_NONE;
            end
         endcase
      end
   end

`ifdef STACK_HIGHWATER_EN
   logic [SPW-1:0] hiwater_q;

   // High-water mark of occupancy; only reset clears it, faults leave it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hiwater_q <= '0;
      end else if (legal && (sp_d > hiwater_q)) begin
         hiwater_q <= sp_d;
      end
   end

   assign hiwater = hiwater_q;
`endif

   assign sp         = sp_q;
   assign empty      = (sp_q == '0);
   assign full       = (sp_q == SPW'(DEPTH));
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule
